// File: rtl/datapath_unit.sv
// Execution datapath: 16x16 register file, 256x16 data memory, ALU and write-back mux.
// Define DATAPATH_FLAGS_EN to build the {N, C, Z} status register; otherwise Flags is 3'b000.
module datapath_unit #(
  parameter int DW = 16,
  parameter int AW = 8,
  parameter int RW = 4
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic [AW-1:0] D_Addr,
  input  logic          D_Wr,
  input  logic          RF_s,
  input  logic          RF_W_en,
  input  logic [RW-1:0] RF_W_Addr,
  input  logic [RW-1:0] RF_Ra_Addr,
  input  logic [RW-1:0] RF_Rb_Addr,
  input  logic [2:0]    ALU_s0,
  output logic [DW-1:0] Ra_Data,
  output logic [DW-1:0] Rb_Data,
  output logic [DW-1:0] ALU_Out,
  output logic [2:0]    Flags
);

  localparam int NREG = 1 << RW;
  localparam int NMEM = 1 << AW;

  localparam logic [2:0] OP_ZERO = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_PASS = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_AND  = 3'd6;
  localparam logic [2:0] OP_INC  = 3'd7;

  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] mem_q [NMEM];
  logic [DW-1:0] r_data_q;
  logic [DW-1:0] r_data_d;
  logic [DW-1:0] rf_wdata;

  assign Ra_Data = rf_q[RF_Ra_Addr];
  assign Rb_Data = rf_q[RF_Rb_Addr];

  always_comb begin
    ALU_Out = '0;
    case (ALU_s0)
      OP_ZERO: ALU_Out = '0;
      OP_ADD:  ALU_Out = Ra_Data + Rb_Data;
      OP_SUB:  ALU_Out = Ra_Data - Rb_Data;
      OP_PASS: ALU_Out = Ra_Data;
      OP_XOR:  ALU_Out = Ra_Data ^ Rb_Data;
      OP_OR:   ALU_Out = Ra_Data | Rb_Data;
      OP_AND:  ALU_Out = Ra_Data & Rb_Data;
      OP_INC:  ALU_Out = Ra_Data + DW'(1);
      default: ALU_Out = '0;
    endcase
  end

  assign rf_wdata = RF_s ? r_data_q : ALU_Out;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (RF_W_en) begin
      rf_q[RF_W_Addr] <= rf_wdata;
    end
  end

  // Memory contents survive reset; reset only blocks writes while it is held.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
    end else if (D_Wr) begin
      mem_q[D_Addr] <= Ra_Data;
    end
  end

  // Sampled from the pre-edge array, so a same-address write returns old data.
  assign r_data_d = mem_q[D_Addr];

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_data_q <= '0;
    end else begin
      r_data_q <= r_data_d;
    end
  end

`ifdef DATAPATH_FLAGS_EN
  logic [DW:0] add_wide;
  logic [DW:0] inc_wide;
  logic        carry;
  logic [2:0]  flags_d;
  logic [2:0]  flags_q;

  assign add_wide = {1'b0, Ra_Data} + {1'b0, Rb_Data};
  assign inc_wide = {1'b0, Ra_Data} + (DW + 1)'(1);

  always_comb begin
    carry = 1'b0;
    case (ALU_s0)
      OP_ADD:  carry = add_wide[DW];
      OP_SUB:  carry = (Ra_Data < Rb_Data);
      OP_INC:  carry = inc_wide[DW];
      default: carry = 1'b0;
    endcase
  end

  // Only ALU write-backs move the flags; loads and idle cycles hold them.
  always_comb begin
    flags_d = flags_q;
    if (RF_W_en && !RF_s) begin
      flags_d = {ALU_Out[DW-1], carry, (ALU_Out == '0)};
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      flags_q <= 3'b000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign Flags = flags_q;
`else
  assign Flags = 3'b000;
`endif

endmodule

// File: doc/datapath_unit.md
# datapath_unit

Execution datapath of the six-instruction processor, directly downstream of the control unit. Consumes the control unit's per-cycle control word (data-memory address/write, register-file addresses/enables, write-back select, ALU select) and performs the work. Contains:
- a 16×16 register file;
- a 256×16 data memory;
- the ALU;
- the write-back mux.

Exposes register read data and ALU result for debug and display.

## Interface
- Parameters:
  - `DW`, default 16: data width. Fixed at 16 for this processor; other values are not supported.
  - `AW`, default 8: data-memory address width.
  - `RW`, default 4: register address width.
- Ports:
  - `Clock`  in  1  rising-edge clock.
  - `Reset`  in  1  asynchronous, active-low reset.
  - `D_Addr`  in  8  data-memory address.
  - `D_Wr`  in  1  data-memory write enable.
  - `RF_s`  in  1  write-back select: 1 = memory read data, 0 = ALU result.
  - `RF_W_en`  in  1  register-file write enable.
  - `RF_W_Addr`  in  4  write register.
  - `RF_Ra_Addr`  in  4  read port A register.
  - `RF_Rb_Addr`  in  4  read port B register.
  - `ALU_s0`  in  3  ALU operation select.
  - `Ra_Data`  out  16  register file port A.
  - `Rb_Data`  out  16  register file port B.
  - `ALU_Out`  out  16  ALU result.
  - `Flags`  out  3  {N, C, Z} status register.

## Operation
- **Register file**
  - 16 entries; all are writable, including R0.
  - Reads are combinational.
  - Write occurs on the rising edge when `RF_W_en`=1. Write data is `RF_s` ? `R_Data` : `ALU_Out`.
  - Read of the address being written in the same cycle returns the old value.
- **Data memory**
  - 256 words.
  - Write on the rising edge when `D_Wr`=1: mem[`D_Addr`] <= `Ra_Data`.
  - Internal read register `R_Data` <= mem[`D_Addr`] every edge, read-first: if write and read target the same address in one edge, the old contents are captured.
- **ALU** (combinational; A = `Ra_Data`, B = `Rb_Data`; results mod 2^16)

  | `ALU_s0` | Result |
  |---|---|
  | 0 | 0 |
  | 1 | A+B |
  | 2 | A−B |
  | 3 | A |
  | 4 | A^B |
  | 5 | A\|B |
  | 6 | A&B |
  | 7 | A+1 |

- **Reset** (`Reset`=0, asynchronous):
  - Clears all 16 registers, `R_Data`, and `Flags` to 0.
  - Memory contents are preserved.
  - Memory and RF writes are suppressed while `Reset` is 0.
- **Output reset values:**
  - `Ra_Data` = `Rb_Data` = 0.
  - `ALU_Out` = 0 for `ALU_s0` ∈ {0,1,2,3,4,5,6}; `ALU_Out` = 1 for `ALU_s0`=7.
  - `Flags` = 0.

## Timing
- Register write becomes visible on `Ra_Data`/`Rb_Data` immediately after the writing edge.
- STORE:
  - One cycle: `Ra_Addr` = source register, `D_Addr` = target address, `D_Wr`=1.
  - Memory is updated at the end of that cycle.
- LOAD (two cycles):
  - Cycle N: `D_Addr` is presented.
  - Cycle N+1: `RF_s`=1, `RF_W_en`=1. The destination register holds mem[`D_Addr` of cycle N] after the edge ending N+1.
- ADD/SUB:
  - One cycle: Ra/Rb/W addresses, `ALU_s0`, `RF_s`=0, `RF_W_en`=1.
  - Result is in the register after that edge.
  - Equal W and Ra addresses are legal: the pre-edge value is used.
- Simultaneous `D_Wr` and `RF_W_en` in one cycle are legal and independent.
- `Reset` deasserted mid-sequence: a LOAD in progress is lost; the control unit restarts from PC=0.

## Configuration
- `DATAPATH_FLAGS_EN` defined:
  - A 3-bit `Flags` register updates on any edge with `RF_W_en`=1 and `RF_s`=0.
  - Z = (result == 0).
  - N = result[15].
  - C = carry out for s=1 and s=7; borrow (A<B) for s=2; 0 otherwise.
  - Flags hold their value on memory loads and on cycles without a write.
- `DATAPATH_FLAGS_EN` undefined:
  - No flag register is synthesized.
  - `Flags` is tied to 3'b000.

## Test plan
- **Reset and load:** `Reset`=0 then 1; preload mem[0x05]=0x1234. LOAD R3 (cycle N `D_Addr`=0x05; cycle N+1 `RF_s`=1, W=3) -> `Ra_Data`=0x1234 when Ra=3, and all other registers read 0.
- **Add and subtract:** R1=0x0003, R2=0x0005.
  - ADD R4=R1+R2 -> R4=0x0008; Flags Z=0 N=0 C=0.
  - SUB R5=R1−R2 -> R5=0xFFFE; N=1 C=1.
- **Wrap and carry:** R6=0xFFFF, `ALU_s0`=7 write R6 -> R6=0x0000; Z=1 C=1 with the flags macro defined, `Flags`=000 without it.
- **Store and read-first:** STORE R4 to mem[0x80] while the same edge captures `R_Data` from mem[0x80] (old value 0xAAAA) -> `R_Data`=0xAAAA; next cycle `R_Data`=0x0008.
- **Self-overwrite:** R7=0x0010; ADD with W=Ra=7, Rb=7 -> R7=0x0020 after one edge, not 0x0040 after two.
- **Reset mid-LOAD:** assert `Reset` low between cycles N and N+1 -> all registers and `Flags` are 0, no write occurs, and mem[0x05] still reads 0x1234.
